// File: rtl/hash_arbiter_pkg.sv
// rtl/hash_arbiter_pkg.sv - shared types and constants for the hash arbiter
package hash_arbiter_pkg;

  localparam int N_REQ_DEFAULT = 4;
  localparam int KEY_W         = 64;
  localparam int DATA_W        = 8;
  localparam int WDOG_W        = 4;
  localparam int WDOG_LIMIT    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/hash.sv
// rtl/hash.sv - shared hash datapath: saturating byte sum of a 64-bit key
module hash
  import hash_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [KEY_W-1:0]  key_i,
  output logic              hash_ready_o,
  output logic [DATA_W-1:0] hash_o
);

  logic [KEY_W-1:0]  key_q;
  logic [1:0]        phase_q;
  logic              ready_q;
  logic [DATA_W-1:0] hash_q;

  // Sum all eight key bytes; results above one byte clamp to all ones.
  function automatic logic [DATA_W-1:0] byte_sat_sum(input logic [KEY_W-1:0] k);
    logic [10:0] acc;
    acc = '0;
    for (int b = 0; b < KEY_W / 8; b++) begin
      acc = acc + {3'b000, k[8*b +: 8]};
    end
    return (acc > 11'd255) ? 8'hFF : acc[7:0];
  endfunction

  // Start latches the key, compute takes one cycle, ready rises the cycle after
  // and stays high until the next start (a stale high the caller must tolerate).
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q   <= '0;
      phase_q <= 2'd0;
      ready_q <= 1'b0;
      hash_q  <= '0;
    end else if (start_i) begin
      key_q   <= key_i;
      phase_q <= 2'd1;
      ready_q <= 1'b0;
    end else if (phase_q == 2'd1) begin
      hash_q  <= byte_sat_sum(key_q);
      phase_q <= 2'd2;
    end else if (phase_q == 2'd2) begin
      ready_q <= 1'b1;
      phase_q <= 2'd0;
    end
  end

  assign hash_ready_o = ready_q;
  assign hash_o       = hash_q;

endmodule

// File: rtl/hash_arbiter.sv
// rtl/hash_arbiter.sv - round-robin arbiter sharing one hash unit among requesters
module hash_arbiter
  import hash_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*KEY_W-1:0] key_i,
  output logic [N_REQ-1:0]       ack_o,
  output logic [DATA_W-1:0]      hash_val_o,
  output logic [$clog2(N_REQ)-1:0] owner_o,
  output logic                   busy_o
);

  localparam int IDX_W = $clog2(N_REQ);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [DATA_W-1:0] hash_val_q, hash_val_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  logic              hash_start;
  logic              hash_ready;
  logic [DATA_W-1:0] hash_data;

  logic              grant_found;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  grant_next_ptr;
  int                cand;

  // Round-robin pick: first set request at or above ptr, wrapping to zero.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = (int'(ptr_q) + i) % N_REQ;
      if (!grant_found && req_i[cand]) begin
        grant_found = 1'b1;
        grant_idx   = IDX_W'(cand);
      end
    end
    grant_next_ptr = (grant_idx == IDX_W'(N_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
  end

  // Next-state logic; the first WAIT cycle (wdog_q == 0) ignores a stale ready.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    key_d      = key_q;
    hash_val_d = hash_val_q;
    wdog_d     = wdog_q;
    hash_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          ptr_d   = grant_next_ptr;
          key_d   = key_i[grant_idx*KEY_W +: KEY_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        hash_start = 1'b1;
        wdog_d     = '0;
        state_d    = WAIT;
      end
      WAIT: begin
        wdog_d = (wdog_q == '1) ? wdog_q : wdog_q + WDOG_W'(1);
        if ((wdog_q != '0) && hash_ready) begin
          hash_val_d = hash_data;
          state_d    = DONE;
        end else if (wdog_q == WDOG_W'(WDOG_LIMIT - 1)) begin
          state_d = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously so an abort never acks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      key_q      <= '0;
      hash_val_q <= '0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      key_q      <= key_d;
      hash_val_q <= hash_val_d;
      wdog_q     <= wdog_d;
    end
  end

  // One-hot ack toward the owner while in DONE.
  always_comb begin
    ack_o = '0;
    if (state_q == DONE) begin
      ack_o[owner_q] = 1'b1;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign owner_o    = owner_q;
  assign hash_val_o = hash_val_q;

  hash u_hash (
    .clk          (clk),
    .rst          (rst),
    .start_i      (hash_start),
    .key_i        (key_q),
    .hash_ready_o (hash_ready),
    .hash_o       (hash_data)
  );

endmodule

// File: tb/tb_hash_arbiter.sv
// tb/tb_hash_arbiter.sv - directed scoreboard bench for hash_arbiter
module tb_hash_arbiter;

  localparam int N = 4;

  typedef struct packed {
    logic [N-1:0] ack;
    logic [7:0]   hash;
    logic [1:0]   owner;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [N*64-1:0] key;
  logic [N-1:0]   ack_o;
  logic [7:0]     hash_val_o;
  logic [1:0]     owner_o;
  logic           busy_o;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  hash_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req),
    .key_i      (key),
    .ack_o      (ack_o),
    .hash_val_o (hash_val_o),
    .owner_o    (owner_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] model_hash(input logic [63:0] k);
    int s = 0;
    for (int b = 0; b < 8; b++) s += int'(k[8*b +: 8]);
    return (s > 255) ? 8'hFF : 8'(s);
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input logic [63:0] kv);
    exp_t e;
    e.ack   = N'(1) << k;
    e.hash  = model_hash(kv);
    e.owner = 2'(k);
    sb.push_back(e);
  endtask

  task automatic expect_ack(input string tag, input int budget, output int at);
    int n = 0;
    exp_t e;
    while (ack_o == '0 && n < budget) begin
      tick();
      n++;
    end
    at = cyc;
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 64'(sb.size()), 64'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_ack"},   64'(ack_o),      64'(e.ack));
      chk({tag, "_hash"},  64'(hash_val_o), 64'(e.hash));
      chk({tag, "_owner"}, 64'(owner_o),    64'(e.owner));
    end
  endtask

  initial begin
    int c, at, prev;
    logic [63:0] kx, ky;
    rst = 1'b1;
    req = '0;
    key = '0;
    tick(); tick();
    chk("rst_ack",   64'(ack_o),      64'd0);
    chk("rst_hash",  64'(hash_val_o), 64'd0);
    chk("rst_owner", 64'(owner_o),    64'd0);
    chk("rst_busy",  64'(busy_o),     64'd0);
    rst = 1'b0;
    tick();

    // Single request from requester 1, exact latency and hold behaviour.
    key[1*64 +: 64] = 64'h0102030405060708;
    req = 4'b0010;
    push(1, 64'h0102030405060708);
    chk("model_0x24", 64'(sb[0].hash), 64'h24);
    c = cyc;
    tick();
    chk("s1_busy", 64'(busy_o), 64'd1);
    expect_ack("s1", 12, at);
    chk("s1_lat", 64'(at - c), 64'd5);
    req[1] = 1'b0;
    tick();
    chk("s1_ack_low", 64'(ack_o),      64'd0);
    chk("s1_idle",    64'(busy_o),     64'd0);
    chk("s1_hold",    64'(hash_val_o), 64'h24);

    // Pointer now at 2: requests 0 and 3 resolve as 3 then 0.
    key[0*64 +: 64] = {$urandom, $urandom};
    key[3*64 +: 64] = {$urandom, $urandom};
    req = 4'b1001;
    push(3, key[3*64 +: 64]);
    push(0, key[0*64 +: 64]);
    expect_ack("rr_a", 12, at);
    req[3] = 1'b0;
    tick();
    expect_ack("rr_b", 12, at);
    req[0] = 1'b0;
    tick();

    // All-ones key saturates; requester 3 leaves the pointer at 0.
    key[3*64 +: 64] = 64'hFFFF_FFFF_FFFF_FFFF;
    req = 4'b1000;
    push(3, 64'hFFFF_FFFF_FFFF_FFFF);
    expect_ack("sat", 12, at);
    chk("sat_val", 64'(hash_val_o), 64'hFF);
    req[3] = 1'b0;
    tick();

    // Four contending requesters, each drops on its own ack.
    for (int k = 0; k < N; k++) key[k*64 +: 64] = {$urandom, $urandom};
    req = 4'b1111;
    for (int k = 0; k < N; k++) push(k, key[k*64 +: 64]);
    prev = 0;
    for (int k = 0; k < N; k++) begin
      expect_ack("all", 12, at);
      if (k > 0) chk("all_spacing", 64'(at - prev), 64'd6);
      prev = at;
      req[k] = 1'b0;
      tick();
      chk("all_gap", 64'(busy_o), 64'd0);
      if (k < N - 1) begin
        tick();
        chk("all_regrant", 64'(busy_o), 64'd1);
      end
    end

    // Reset during WAIT aborts; the still-held request then completes.
    kx = {$urandom, $urandom};
    key[2*64 +: 64] = kx;
    req = 4'b0100;
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("ra_ack",   64'(ack_o),      64'd0);
    chk("ra_hash",  64'(hash_val_o), 64'd0);
    chk("ra_owner", 64'(owner_o),    64'd0);
    chk("ra_busy",  64'(busy_o),     64'd0);
    tick();
    rst = 1'b0;
    c = cyc;
    push(2, kx);
    expect_ack("ra_redo", 12, at);
    chk("ra_lat", 64'(at - c), 64'd5);
    req[2] = 1'b0;
    tick();

    // Hash ready stuck low: watchdog gives up after eight WAIT cycles.
    force dut.hash_ready = 1'b0;
    ky = {$urandom, $urandom};
    key[1*64 +: 64] = ky;
    req = 4'b0010;
    for (int i = 1; i <= 10; i++) begin
      tick();
      chk("wd_noack", 64'(ack_o), 64'd0);
      if (i == 9) chk("wd_busy9", 64'(busy_o), 64'd1);
    end
    chk("wd_idle",  64'(busy_o),     64'd0);
    chk("wd_hash",  64'(hash_val_o), 64'(model_hash(kx)));
    chk("wd_owner", 64'(owner_o),    64'd1);
    req[1] = 1'b0;
    release dut.hash_ready;
    tick();
    chk("wd_stay_idle", 64'(busy_o), 64'd0);

    // Recovery after the watchdog abort.
    req = 4'b0010;
    push(1, ky);
    expect_ack("wd_recover", 12, at);
    req[1] = 1'b0;
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hash_arbiter.md
HASH_ARBITER -- requirements
Module: hash_arbiter

Interface
REQ-001 The parameter SHALL be N_REQ, default 4; number of requesters sharing one hash unit; range 2..8.
REQ-002 The port list SHALL be: clk  in  1  single clock, rising edge.
REQ-003 The port list SHALL include: rst  in  1  asynchronous, active-high reset.
REQ-004 The port list SHALL include: req_i  in  N_REQ  level request, one bit per requester.
REQ-005 The port list SHALL include: key_i  in  N_REQ*64  packed keys; requester k owns bits [64k+63:64k]; each key is a `QUAD_BUS value.
REQ-006 The port list SHALL include: ack_o  out  N_REQ  one-cycle result-valid strobe, one-hot.
REQ-007 The port list SHALL include: hash_val_o  out  `DATA_BUS  result for the acked requester.
REQ-008 The port list SHALL include: owner_o  out  $clog2(N_REQ)  index of the current or last granted requester.
REQ-009 The port list SHALL include: busy_o  out  1  high in every state except IDLE.

Function
REQ-010 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, DONE.
REQ-011 IDLE, any req_i set: on the edge, grant via round-robin; latch owner and that requester's key; go to ISSUE.
REQ-012 IDLE, no req_i set: remain in IDLE.
REQ-013 Round-robin SHALL search upward from pointer ptr with wrap (ptr, ptr+1, …, N_REQ-1, 0, …).
REQ-014 On each grant, ptr SHALL become (owner+1) mod N_REQ.
REQ-015 ISSUE SHALL drive start_i=1 to the hash unit for exactly one cycle, key_i = latched key, then go to WAIT.
REQ-016 In every state other than ISSUE, start_i to the hash unit SHALL be 0.
REQ-017 WAIT SHALL ignore hash_ready_o during the first WAIT cycle, because a stale high may persist from the previous operation.
REQ-018 From the second WAIT cycle on, hash_ready_o=1 SHALL capture the hash value into hash_val_o and move the FSM to DONE.
REQ-019 DONE SHALL drive ack_o[owner]=1 for exactly one cycle, then go to IDLE; all other ack_o bits SHALL remain 0.
REQ-020 Latency SHALL be 5 edges: req sampled at edge E0 → ack_o high after E4, low after E5; next grant no earlier than E6; one operation per 6 cycles.
REQ-021 Requesters SHALL hold key_i stable and req_i high until ack is seen, then drop req_i by the next edge; the IDLE state after DONE guarantees a dropped request is never re-granted.
REQ-022 hash_val_o SHALL hold its value until the next capture.
REQ-023 owner_o SHALL update on each grant and hold its value until the next grant.
REQ-024 The watchdog SHALL count WAIT cycles with a 4-bit saturating counter; on reaching 8 the FSM goes to IDLE, no ack_o is issued, and hash_val_o is unchanged.
REQ-025 If req_i bits change while the FSM is in ISSUE, WAIT or DONE, the operation in progress SHALL be unaffected.

Reset
REQ-026 While rst=1, asynchronously: state=IDLE, ptr=0, owner_o=0, ack_o=0, hash_val_o=`ZERO_WORD, busy_o=0, start_i=0, watchdog counter=0.
REQ-027 Reset in ISSUE, WAIT or DONE SHALL abort the operation with no ack_o strobe.
REQ-028 rst SHALL be forwarded to the hash instance and held for at least one rising clk edge, because that instance resets synchronously.

Structure
REQ-029 The shared package SHALL hold: the state enum, N_REQ default, key width 64, and watchdog limit 8.
REQ-030 The block SHALL instantiate exactly one sub-module, hash (existing), as the shared datapath.

Verification
REQ-031 Single request, req_i=0010, key=0x0102030405060708 → ack_o=0010 after E4, hash_val_o=0x24, owner_o=1.
REQ-032 Single request, key=0xFFFFFFFFFFFFFFFF → hash_val_o=0xFF.
REQ-033 req_i=1111 held, each requester dropping on its ack → acks in order 0,1,2,3, 6 cycles apart, busy_o gaps one cycle.
REQ-034 ptr=2, req_i=1001 → requester 3 granted first, then requester 0.
REQ-035 rst pulsed during WAIT → no ack_o; all outputs at reset values; a subsequent request completes with the correct hash value.
REQ-036 Hash ready forced low → after 8 WAIT cycles return to IDLE, ack_o stays 0000, hash_val_o unchanged.
